cache_set_ctrl: RTL and testbench
=================================

Name: cache_set_ctrl

Overview:
- Controller for one 8-way cache set. It is the initiator on the LRU interface: it drives the accessed way index and the hit flag to the LRU square, and it consumes the LRU way when it must pick a victim.
- Accepts read/write requests from the core through a valid/ready handshake. Performs the tag lookup. On a miss it fetches from memory over a req/ack handshake and fills the victim way. Writes are write-through, no-allocate.

Parameters:
- TAG_W, 8, tag width in bits.
- DATA_W, 8, line (word) width in bits.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  controller can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_tag  input  TAG_W  request tag.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  one-cycle response strobe.
- resp_hit  output  1  request hit in the set.
- resp_data  output  DATA_W  read data (hit or fill data); 0 for writes.
- lru_way  input  3  current LRU way from the LRU square.
- lru_index  output  3  way accessed, to the LRU square.
- lru_hit  output  1  1 = lru_index is a hit way, 0 = lru_index is a fill way.
- lru_touch  output  1  one-cycle strobe: the LRU square updates only when this is 1.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = memory write, 0 = memory read.
- mem_tag  output  TAG_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ack  input  1  memory completion.
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack = 1.

Behaviour:
- Storage: 8 entries of {valid, tag, data}.
- Reset (reset = 0, asynchronous):
  - All valid bits clear; FSM goes to IDLE.
  - req_ready = 1.
  - All other outputs are 0.
  - Any in-flight memory transaction is abandoned: mem_req drops, no install, no response, no touch.
- FSM states: IDLE, LOOKUP, MEM, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch wr, tag and wdata, then go to LOOKUP.
  - req_ready = 0 in every other state; there is no pipelining and exactly one request is outstanding.
- LOOKUP (exactly 1 cycle):
  - Compare the latched tag with every valid entry; at most one can match.
  - Victim on a miss: the lowest-index invalid way if one exists, otherwise lru_way sampled in this cycle.
  - Read hit: capture the entry data, then go to RESP.
  - Write hit: overwrite the hit entry's data with wdata, then go to MEM with mem_we = 1.
  - Read miss: go to MEM with mem_we = 0.
  - Write miss: go to MEM with mem_we = 1; no allocation.
- MEM:
  - mem_req = 1; mem_we, mem_tag and mem_wdata stay stable until a posedge where mem_ack = 1.
  - mem_ack is only meaningful while mem_req = 1 and is ignored otherwise.
  - On ack for a read: install {valid = 1, tag, mem_rdata} in the victim way and capture mem_rdata as response data.
  - On ack for a write: no array change.
  - After ack: mem_req = 0 in the next cycle, then go to RESP.
- RESP (exactly 1 cycle):
  - resp_valid = 1; resp_hit and resp_data are as captured.
  - lru_touch = 1 with lru_index = hit way (lru_hit = 1) on any hit, or victim way (lru_hit = 0) on a read miss.
  - No touch on a write miss.
  - Then go to IDLE. Response and LRU outputs are 0 outside RESP.
- There is no response backpressure; the core must accept resp_valid whenever it occurs.
- Latency, counted from the acceptance edge:
  - Read hit: resp_valid in cycle +2.
  - Miss or write: resp_valid in cycle +3 + N, where N is the number of cycles mem_req is high before ack (ack in the first MEM cycle gives N = 0).
- Simultaneous events:
  - req_valid in a non-IDLE state is held off by req_ready = 0.
  - mem_ack together with reset: reset wins.

Test Plan:
- Reset, then read tag 0x12; mem_ack after 3 cycles with mem_rdata 0xA5 → mem_req/mem_we = 1/0 with mem_tag 0x12; resp_hit = 0, resp_data = 0xA5; lru_touch with lru_index 0, lru_hit 0.
- Read 0x12 again → no mem_req; resp_valid exactly 2 cycles after acceptance, resp_hit = 1, resp_data = 0xA5; lru_touch with index 0, lru_hit 1.
- Fill tags 0x10..0x17 into ways 0..7, then read 0x20 with lru_way = 3 → way 3 is replaced; a subsequent read of 0x13 misses and a read of 0x20 hits in way 3.
- Write hit to 0x12 with data 0x3C → mem write with tag 0x12 and data 0x3C; resp_hit = 1; touch way 0. A later read of 0x12 hits with resp_data 0x3C.
- Write miss to 0x55 → mem write occurs; resp_hit = 0; no lru_touch; a later read of 0x55 misses.
- Assert reset while in MEM with mem_req = 1 → mem_req falls immediately; no resp_valid; all ways invalid; req_ready = 1 after reset is released.

Source files
------------

// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: controller for a single 8-way cache set.
//
// Core side   : req_valid/req_ready handshake carrying req_wr, req_tag and
//               req_wdata; one-cycle resp_valid strobe with resp_hit and
//               resp_data (zero for writes). One request outstanding at a time.
// LRU side    : lru_way in (current LRU way); lru_index/lru_hit/lru_touch out.
//               lru_touch is a one-cycle strobe in the response cycle.
// Memory side : mem_req held until mem_ack; mem_we/mem_tag/mem_wdata stable
//               while mem_req is high; mem_rdata valid with mem_ack.
// Debug       : state_dbg exposes the FSM state (IDLE=0, LOOKUP=1, MEM=2, RESP=3).
//
// Handshakes: a core request transfers on a posedge where req_valid and
// req_ready are both 1; a memory transaction completes on a posedge where
// mem_req and mem_ack are both 1 (mem_ack is ignored while mem_req is 0).
// Writes are write-through and never allocate a way.
module cache_set_ctrl #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  input  logic [2:0]        lru_way,
  output logic [2:0]        lru_index,
  output logic              lru_hit,
  output logic              lru_touch,
  output logic              mem_req,
  output logic              mem_we,
  output logic [TAG_W-1:0]  mem_tag,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, MEM = 2'd2, RESP = 2'd3} state_t;

  state_t state, state_nx;

  // Set storage
  logic [7:0]        way_valid;
  logic [TAG_W-1:0]  way_tag  [8];
  logic [DATA_W-1:0] way_data [8];

  // Latched request and captured lookup result
  logic              cur_wr;
  logic [TAG_W-1:0]  cur_tag;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_hit;
  logic [2:0]        cur_way;   // hit way on a hit, victim way on a miss
  logic [DATA_W-1:0] cur_data;

  // Tag compare and lowest free way
  logic       look_hit;
  logic [2:0] look_hit_way;
  logic       look_free;
  logic [2:0] look_free_way;

  always_comb begin
    look_hit      = 1'b0;
    look_hit_way  = 3'd0;
    look_free     = 1'b0;
    look_free_way = 3'd0;
    // Scan from the top down so the lowest-index free way is the last written.
    for (int i = 7; i >= 0; i--) begin
      if (way_valid[i] && (way_tag[i] == cur_tag)) begin
        look_hit     = 1'b1;
        look_hit_way = 3'(i);
      end
      if (!way_valid[i]) begin
        look_free     = 1'b1;
        look_free_way = 3'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state and outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_data  = '0;
    lru_index  = 3'd0;
    lru_hit    = 1'b0;
    lru_touch  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_tag    = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = LOOKUP;
      end
      LOOKUP: begin
        if (look_hit && !cur_wr) state_nx = RESP;
        else                     state_nx = MEM;
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = cur_wr;
        mem_tag   = cur_tag;
        mem_wdata = cur_wdata;
        if (mem_ack) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = cur_hit;
        resp_data  = cur_data;
        // A write miss leaves the LRU order untouched.
        lru_touch  = cur_hit | ~cur_wr;
        lru_hit    = cur_hit;
        lru_index  = cur_way;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Request latch, lookup capture and valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      way_valid <= '0;
      cur_wr    <= 1'b0;
      cur_tag   <= '0;
      cur_wdata <= '0;
      cur_hit   <= 1'b0;
      cur_way   <= 3'd0;
      cur_data  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cur_wr    <= req_wr;
          cur_tag   <= req_tag;
          cur_wdata <= req_wdata;
        end
        LOOKUP: begin
          cur_hit  <= look_hit;
          cur_way  <= look_hit ? look_hit_way : (look_free ? look_free_way : lru_way);
          cur_data <= (look_hit && !cur_wr) ? way_data[look_hit_way] : '0;
        end
        MEM: if (mem_ack && !cur_wr) begin
          way_valid[cur_way] <= 1'b1;
          cur_data           <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; a cleared valid bit makes their contents
  // irrelevant. Writes are gated by reset so an abandoned fill cannot land.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == LOOKUP && look_hit && cur_wr)
        way_data[look_hit_way] <= cur_wdata;
      if (state == MEM && mem_ack && !cur_wr) begin
        way_tag[cur_way]  <= cur_tag;
        way_data[cur_way] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_set_ctrl.sv
module tb_cache_set_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [7:0] req_tag = '0, req_wdata = '0;
  logic       resp_valid, resp_hit;
  logic [7:0] resp_data;
  logic [2:0] lru_way = '0, lru_index;
  logic       lru_hit, lru_touch;
  logic       mem_req, mem_we, mem_ack = 1'b0;
  logic [7:0] mem_tag, mem_wdata, mem_rdata = '0;
  logic [1:0] state_dbg;

  cache_set_ctrl #(.TAG_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_tag(req_tag), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .lru_way(lru_way), .lru_index(lru_index), .lru_hit(lru_hit), .lru_touch(lru_touch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_tag(mem_tag), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model: the set as a plain table ----------------
  bit         m_valid [8];
  logic [7:0] m_tag   [8];
  logic [7:0] m_data  [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_access(input bit wr, input logic [7:0] tag, input logic [7:0] wdata,
                              input logic [2:0] lru, input logic [7:0] rdata,
                              output bit e_hit, output logic [7:0] e_data,
                              output bit e_touch, output logic [2:0] e_idx);
    int hw, fw, vic;
    hw = -1; fw = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_tag[i] == tag) hw = i;
      if (!m_valid[i] && fw < 0) fw = i;
    end
    e_hit = (hw >= 0);
    if (e_hit) begin
      if (wr) m_data[hw] = wdata;
      e_data  = wr ? 8'h00 : m_data[hw];
      e_touch = 1'b1;
      e_idx   = 3'(hw);
    end else if (wr) begin
      e_data = 8'h00; e_touch = 1'b0; e_idx = 3'd0;
    end else begin
      vic = (fw >= 0) ? fw : int'(lru);
      m_valid[vic] = 1'b1; m_tag[vic] = tag; m_data[vic] = rdata;
      e_data = rdata; e_touch = 1'b1; e_idx = 3'(vic);
    end
  endtask

  // ---------------- driver: one request, observations recorded ----------------
  bit         obs_done, obs_hit, obs_lru_hit, obs_ready0, obs_unstable;
  int         obs_lat, obs_touch_cnt, obs_mem_cnt, obs_ready_busy;
  logic [7:0] obs_data, obs_mem_tag, obs_mem_wdata;
  logic [2:0] obs_idx;
  bit         obs_mem_we;

  task automatic run_req(input bit wr, input logic [7:0] tag, input logic [7:0] wdata,
                         input logic [2:0] lru, input int delay, input logic [7:0] rdata);
    int cyc, n;
    obs_done = 0; obs_hit = 0; obs_lru_hit = 0; obs_unstable = 0; obs_lat = -1;
    obs_touch_cnt = 0; obs_mem_cnt = 0; obs_ready_busy = 0; obs_data = '0;
    obs_mem_tag = '0; obs_mem_wdata = '0; obs_idx = '0; obs_mem_we = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_tag = tag; req_wdata = wdata; lru_way = lru;
    obs_ready0 = req_ready;
    @(posedge clk); #1;
    // Scramble the request bus so only latched values can reach memory.
    req_valid = 1'b0; req_tag = 8'($urandom); req_wdata = 8'($urandom); req_wr = 1'($urandom);
    cyc = 0; n = 0;
    while (!obs_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (req_ready) obs_ready_busy++;
      if (mem_req) begin
        if (n == 0) begin
          obs_mem_we = mem_we; obs_mem_tag = mem_tag; obs_mem_wdata = mem_wdata;
        end else if (mem_we !== obs_mem_we || mem_tag !== obs_mem_tag || mem_wdata !== obs_mem_wdata)
          obs_unstable = 1;
        if (n == delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
        n++;
      end else begin
        // Stray acks while no request is pending must be ignored.
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
      end
      if (lru_touch) begin obs_touch_cnt++; obs_idx = lru_index; obs_lru_hit = lru_hit; end
      if (resp_valid) begin
        obs_done = 1; obs_lat = cyc; obs_hit = resp_hit; obs_data = resp_data;
        if (req_ready) obs_ready_busy--;
      end
    end
    mem_ack = 1'b0;
    obs_mem_cnt = n;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_one_access(input string nm, input bit wr, input logic [7:0] tag,
                                 input logic [7:0] wdata, input logic [2:0] lru,
                                 input int delay, input logic [7:0] rdata);
    bit e_hit, e_touch, e_mem;
    logic [7:0] e_data;
    logic [2:0] e_idx;
    int e_lat;
    model_access(wr, tag, wdata, lru, rdata, e_hit, e_data, e_touch, e_idx);
    e_mem = wr || !e_hit;
    e_lat = e_mem ? 3 + delay : 2;
    run_req(wr, tag, wdata, lru, delay, rdata);
    n_cmp++; if (obs_ready0 !== 1'b1) begin n_bad++; $display("FAIL %s ready_idle got=%0b exp=1", nm, obs_ready0); end
    n_cmp++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL %s no_response within budget", nm); end
    n_cmp++; if (obs_lat !== e_lat) begin n_bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, obs_lat, e_lat); end
    n_cmp++; if (obs_hit !== e_hit) begin n_bad++; $display("FAIL %s resp_hit got=%0b exp=%0b", nm, obs_hit, e_hit); end
    n_cmp++; if (obs_data !== e_data) begin n_bad++; $display("FAIL %s resp_data got=%h exp=%h", nm, obs_data, e_data); end
    n_cmp++; if (obs_touch_cnt !== int'(e_touch)) begin n_bad++; $display("FAIL %s touch_count got=%0d exp=%0d", nm, obs_touch_cnt, e_touch); end
    if (e_touch) begin
      n_cmp++; if (obs_idx !== e_idx) begin n_bad++; $display("FAIL %s lru_index got=%0d exp=%0d", nm, obs_idx, e_idx); end
      n_cmp++; if (obs_lru_hit !== e_hit) begin n_bad++; $display("FAIL %s lru_hit got=%0b exp=%0b", nm, obs_lru_hit, e_hit); end
    end
    n_cmp++; if (obs_mem_cnt !== (e_mem ? delay + 1 : 0)) begin n_bad++; $display("FAIL %s mem_req_cycles got=%0d exp=%0d", nm, obs_mem_cnt, e_mem ? delay + 1 : 0); end
    if (e_mem) begin
      n_cmp++; if (obs_mem_we !== wr) begin n_bad++; $display("FAIL %s mem_we got=%0b exp=%0b", nm, obs_mem_we, wr); end
      n_cmp++; if (obs_mem_tag !== tag) begin n_bad++; $display("FAIL %s mem_tag got=%h exp=%h", nm, obs_mem_tag, tag); end
      if (wr) begin
        n_cmp++; if (obs_mem_wdata !== wdata) begin n_bad++; $display("FAIL %s mem_wdata got=%h exp=%h", nm, obs_mem_wdata, wdata); end
      end
      n_cmp++; if (obs_unstable !== 1'b0) begin n_bad++; $display("FAIL %s mem_stable got=changed exp=stable", nm); end
    end
    n_cmp++; if (obs_ready_busy !== 0) begin n_bad++; $display("FAIL %s ready_while_busy got=%0d exp=0", nm, obs_ready_busy); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready got=%0b exp=1", req_ready); end
    n_cmp++; if ({resp_valid, resp_hit, resp_data} !== 10'd0) begin n_bad++; $display("FAIL reset resp got=%h exp=0", {resp_valid, resp_hit, resp_data}); end
    n_cmp++; if ({lru_touch, lru_hit, lru_index} !== 5'd0) begin n_bad++; $display("FAIL reset lru got=%h exp=0", {lru_touch, lru_hit, lru_index}); end
    n_cmp++; if ({mem_req, mem_we, mem_tag, mem_wdata} !== 18'd0) begin n_bad++; $display("FAIL reset mem got=%h exp=0", {mem_req, mem_we, mem_tag, mem_wdata}); end
    @(negedge clk); reset = 1'b1;
    model_clear();
  endtask

  task automatic test_read_miss_hit();
    test_one_access("read_miss_12", 1'b0, 8'h12, 8'h00, 3'd6, 3, 8'hA5);
    n_cmp++; if (obs_idx !== 3'd0) begin n_bad++; $display("FAIL read_miss_12 way got=%0d exp=0", obs_idx); end
    test_one_access("read_hit_12", 1'b0, 8'h12, 8'h00, 3'd6, 0, 8'h00);
    n_cmp++; if (obs_data !== 8'hA5) begin n_bad++; $display("FAIL read_hit_12 data got=%h exp=a5", obs_data); end
  endtask

  task automatic test_write_through();
    test_one_access("write_hit_12", 1'b1, 8'h12, 8'h3C, 3'd2, 1, 8'h77);
    test_one_access("read_after_wr", 1'b0, 8'h12, 8'h00, 3'd2, 0, 8'h77);
    n_cmp++; if (obs_data !== 8'h3C) begin n_bad++; $display("FAIL read_after_wr data got=%h exp=3c", obs_data); end
    test_one_access("write_miss_55", 1'b1, 8'h55, 8'h9E, 3'd4, 2, 8'h11);
    test_one_access("read_55_miss", 1'b0, 8'h55, 8'h00, 3'd4, 0, 8'h66);
    n_cmp++; if (obs_hit !== 1'b0) begin n_bad++; $display("FAIL read_55_miss hit got=%0b exp=0", obs_hit); end
  endtask

  task automatic test_reset_in_mem();
    int cyc, seen;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_tag = 8'h99; lru_way = 3'd1;
    @(posedge clk); #1; req_valid = 1'b0;
    cyc = 0; seen = 0;
    while (seen < 2 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (mem_req) seen++;
    end
    n_cmp++; if (seen !== 2) begin n_bad++; $display("FAIL rst_mem reach_mem got=%0d exp=2", seen); end
    mem_ack = 1'b1; mem_rdata = 8'hEE;   // ack coincides with reset: reset wins
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem mem_req got=%0b exp=0", mem_req); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mem req_ready got=%0b exp=1", req_ready); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || lru_touch || mem_req) seen++;
    end
    mem_ack = 1'b0;
    reset = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || lru_touch || mem_req) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mem stray_activity got=%0d exp=0", seen); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mem ready_after got=%0b exp=1", req_ready); end
    test_one_access("post_rst_12", 1'b0, 8'h12, 8'h00, 3'd5, 0, 8'h21);
    n_cmp++; if (obs_hit !== 1'b0 || obs_idx !== 3'd0) begin n_bad++; $display("FAIL post_rst_12 hit/way got=%0b/%0d exp=0/0", obs_hit, obs_idx); end
    test_one_access("post_rst_99", 1'b0, 8'h99, 8'h00, 3'd5, 0, 8'h22);
    n_cmp++; if (obs_hit !== 1'b0) begin n_bad++; $display("FAIL post_rst_99 hit got=%0b exp=0", obs_hit); end
  endtask

  task automatic test_lru_replace();
    @(negedge clk); reset = 1'b0; @(negedge clk); reset = 1'b1; model_clear();
    for (int i = 0; i < 8; i++)
      test_one_access("fill", 1'b0, 8'h10 + 8'(i), 8'h00, 3'($urandom_range(0, 7)), i % 3, 8'hC0 + 8'(i));
    test_one_access("evict_lru3", 1'b0, 8'h20, 8'h00, 3'd3, 1, 8'h5A);
    n_cmp++; if (obs_idx !== 3'd3) begin n_bad++; $display("FAIL evict_lru3 way got=%0d exp=3", obs_idx); end
    test_one_access("read_13_gone", 1'b0, 8'h13, 8'h00, 3'd5, 0, 8'hB3);
    n_cmp++; if (obs_hit !== 1'b0) begin n_bad++; $display("FAIL read_13_gone hit got=%0b exp=0", obs_hit); end
    test_one_access("read_20_hit", 1'b0, 8'h20, 8'h00, 3'd0, 0, 8'h00);
    n_cmp++; if (obs_hit !== 1'b1 || obs_idx !== 3'd3) begin n_bad++; $display("FAIL read_20_hit hit/way got=%0b/%0d exp=1/3", obs_hit, obs_idx); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++)
      test_one_access("random", ($urandom_range(0, 3) == 0), 8'h40 + 8'($urandom_range(0, 11)),
                      8'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3), 8'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_through();
    test_reset_in_mem();
    test_lru_replace();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
